// File: rtl/apb2_led_bank.sv
// rtl/apb2_led_bank.sv - APB2 register bank driving PWM-dimmed, optionally blinking LEDs
// Define APB2_LED_BANK_BLINK_EN to build the blink prescaler, BLINK_DIV and per-channel blink_en.
module apb2_led_bank #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [7:0]          paddr,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    input  logic [2:0]          pprot,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [NUM_LEDS-1:0] led_state
);

    localparam logic [5:0] CH_FIRST = 6'd4;
    localparam logic [5:0] CH_LAST  = 6'(4 + NUM_LEDS - 1);

    logic [NUM_LEDS-1:0] enable_q;
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [NUM_LEDS-1:0] blink_en;
    logic [23:0]         blink_div_q;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] raw;
    logic [NUM_LEDS-1:0] led_q;

    logic [5:0]  word;
    logic [5:0]  ch_off;
    logic        ch_hit;
    logic        err;
    logic        wr;
    logic [31:0] rd;
    logic [31:0] wmask;

    assign word   = paddr[7:2];
    assign ch_off = word - CH_FIRST;
    assign ch_hit = (word >= CH_FIRST) && (word <= CH_LAST);
    assign wmask  = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

    // Decode and read mux share one structure so pslverr and prdata never disagree.
    always_comb begin
        rd  = '0;
        err = 1'b0;
        if (paddr[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (word == 6'd0) begin
            rd[NUM_LEDS-1:0] = enable_q;
        end else if (word == 6'd1) begin
            rd[23:0] = blink_div_q;
        end else if (word == 6'd2) begin
            rd[0]     = blink_phase;
            rd[31:16] = 16'(PWM_BITS);
            err       = pwrite;
        end else if (ch_hit) begin
            for (int c = 0; c < NUM_LEDS; c++) begin
                if (ch_off == 6'(c)) begin
                    rd[PWM_BITS-1:0] = duty_q[c];
                    rd[24]           = blink_en[c];
                end
            end
        end else begin
            err = 1'b1;
        end
    end

    assign wr      = psel & penable & pwrite & ~err;
    assign pready  = 1'b1;
    assign pslverr = psel & penable & err;
    assign prdata  = psel ? rd : '0;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            enable_q <= '0;
            for (int c = 0; c < NUM_LEDS; c++) duty_q[c] <= '0;
        end else if (wr) begin
            if (word == 6'd0) begin
                for (int i = 0; i < NUM_LEDS; i++)
                    if (wmask[i]) enable_q[i] <= pwdata[i];
            end
            if (ch_hit) begin
                for (int c = 0; c < NUM_LEDS; c++) begin
                    if (ch_off == 6'(c)) begin
                        for (int j = 0; j < PWM_BITS; j++)
                            if (wmask[j]) duty_q[c][j] <= pwdata[j];
                    end
                end
            end
        end
    end

`ifdef APB2_LED_BANK_BLINK_EN
    logic [23:0] presc_q;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            blink_div_q <= '0;
            blink_en    <= '0;
            presc_q     <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr && word == 6'd1) begin
                for (int j = 0; j < 24; j++)
                    if (wmask[j]) blink_div_q[j] <= pwdata[j];
            end
            if (wr && ch_hit && pstrb[3]) begin
                for (int c = 0; c < NUM_LEDS; c++)
                    if (ch_off == 6'(c)) blink_en[c] <= pwdata[24];
            end
            // A BLINK_DIV write restarts the period but keeps the current phase.
            if (wr && word == 6'd1) begin
                presc_q <= '0;
            end else if (presc_q == blink_div_q) begin
                presc_q     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                presc_q <= presc_q + 24'd1;
            end
        end
    end
`else
    assign blink_div_q = '0;
    assign blink_en    = '0;
    assign blink_phase = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!preset_n) pwm_cnt <= '0;
        else           pwm_cnt <= pwm_cnt + 1'b1;
    end

    // All-ones duty is forced on so full brightness has no dark cycle at wrap.
    always_comb begin
        raw = '0;
        for (int c = 0; c < NUM_LEDS; c++)
            raw[c] = (&duty_q[c]) | (pwm_cnt < duty_q[c]);
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            led_q <= '0;
        end else begin
            for (int c = 0; c < NUM_LEDS; c++)
                led_q[c] <= enable_q[c] & raw[c] & (~blink_en[c] | blink_phase);
        end
    end

    assign led_state = led_q;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, pprot, pwdata, pstrb};

endmodule

// File: doc/apb2_led_bank.md
APB2_LED_BANK -- requirements
Module: apb2_led_bank

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, LED channel count (legal 1..32).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter/duty width (legal 2..16).
REQ-003 SHALL have port pclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port preset_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have ports psel, penable, pwrite, input, 1 each, APB2 access control.
REQ-006 SHALL have port paddr, input, 8, byte address.
REQ-007 SHALL have ports pwdata (input, 32), pstrb (input, 4), pprot (input, 3); pprot ignored.
REQ-008 SHALL have ports prdata (output, 32), pready (output, 1), pslverr (output, 1).
REQ-009 SHALL have port led_state, output, NUM_LEDS, active-high LED drive.

Function
REQ-010 SHALL define the register map: 0x00 ENABLE[NUM_LEDS-1:0]; 0x04 BLINK_DIV[23:0]; 0x08 STATUS (RO: bit0 blink phase, [31:16] PWM_BITS); 0x10+4*i CH_i (duty[PWM_BITS-1:0], bit 24 blink_en).
REQ-011 SHALL commit a write on the pclk edge where psel&penable&pwrite are high, updating only the bytes whose pstrb bit is set.
REQ-012 SHALL hold pready at 1 always (zero wait states).
REQ-013 SHALL drive prdata combinationally from the addressed register while psel is high, unimplemented bits read 0, prdata = 0 when psel is low.
REQ-014 SHALL assert pslverr during the access phase for addresses outside the map, for paddr[1:0] != 0, or for writes to STATUS; such writes SHALL change no state.
REQ-015 SHALL run a free-running PWM_BITS counter pwm_cnt, incrementing every cycle and wrapping from all-ones to 0.
REQ-016 SHALL compute channel raw_i = 1 when duty_i is all-ones, else (pwm_cnt < duty_i); duty 0 yields constant off.
REQ-017 SHALL run a 24-bit blink prescaler that counts 0..BLINK_DIV and on reaching BLINK_DIV resets to 0 and toggles blink_phase; BLINK_DIV = 0 toggles every cycle.
REQ-018 SHALL restart the prescaler at 0 (blink_phase unchanged) on any write to BLINK_DIV.
REQ-019 SHALL compute led_state[i] = ENABLE[i] & raw_i & (~blink_en_i | blink_phase), registered (one pclk latency from pwm_cnt/register state).
REQ-020 SHALL make register writes visible on led_state no later than the second pclk edge after the write edge.
REQ-021 SHALL, on simultaneous ENABLE write and PWM wrap, use the new ENABLE value from the following cycle with no glitch beyond one cycle.

Reset
REQ-022 SHALL, with preset_n low at a pclk edge, clear ENABLE, BLINK_DIV, all CH_i, pwm_cnt, prescaler and blink_phase to 0.
REQ-023 SHALL drive led_state = 0, pslverr = 0, prdata = 0, pready = 1 during and after reset until registers are written.
REQ-024 SHALL abort any in-progress APB access when reset occurs mid-transfer, committing no write.

Configuration
REQ-025 SHALL, with macro APB2_LED_BANK_BLINK_EN defined, implement the blink prescaler, BLINK_DIV and blink_en as above.
REQ-026 SHALL, without APB2_LED_BANK_BLINK_EN, omit prescaler logic: BLINK_DIV and blink_en read 0, their writes are ignored without pslverr, STATUS bit0 reads 0, led_state[i] = ENABLE[i] & raw_i.

Verification
REQ-027 SHALL cover: reset, read 0x00/0x04/0x10 -> prdata 0, pslverr 0, led_state 0.
REQ-028 SHALL cover: PWM_BITS=8, ENABLE=0x1, CH_0 duty=0x40 -> led_state[0] high 64 of every 256 cycles; duty=0xFF -> constant high; duty=0 -> constant low.
REQ-029 SHALL cover: BLINK_DIV=3, CH_1 duty=0xFF, blink_en=1, ENABLE=0x2 -> led_state[1] toggles every 4 cycles (4 on/4 off).
REQ-030 SHALL cover: write 0x12345678 to CH_0 with pstrb=0b0001 -> only duty low byte becomes 0x78; read of 0x40 with NUM_LEDS=4 -> pslverr 1, prdata 0; write STATUS -> pslverr 1, no change.
REQ-031 SHALL cover: preset_n low in the access phase of a write to ENABLE=0xF -> ENABLE reads 0 afterward, led_state 0.
REQ-032 SHALL cover: build without APB2_LED_BANK_BLINK_EN, write CH_0 = 0x0100_00FF, ENABLE=1 -> readback 0x0000_00FF, led_state[0] constant high.
